// File: rtl/apb3_pkg.sv
// -----------------------------------------------------------------------------
// apb3_pkg
// Shared definitions for the APB3 master: the FSM state encoding, the default
// APB3 bus widths, and a helper that sizes the ACCESS wait counter.
// No ports (package).
// -----------------------------------------------------------------------------
package apb3_pkg;

    localparam int APB3_ADDR_WIDTH = 12;
    localparam int APB3_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb3_state_e;

    // Counter wide enough to hold 0..timeout; a disabled timeout (0) still
    // needs a one-bit counter so the declaration stays legal.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : apb3_pkg

// File: rtl/apb3_master.sv
// -----------------------------------------------------------------------------
// apb3_master
// Converts a valid/ready command into one APB3 transfer (SETUP then ACCESS)
// and returns the result on a valid/ready response channel. A transfer whose
// slave holds PREADY low for TIMEOUT_CYCLES ACCESS cycles is ended with
// rsp_err=1 and rsp_timeout=1 (TIMEOUT_CYCLES=0 waits forever).
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/addr/wdata        command fields
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/err/timeout       response fields (rdata is 0 for writes)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB3 request (registered)
//   PRDATA/PREADY/PSLVERROR     APB3 completion from the slave
// -----------------------------------------------------------------------------
module apb3_master
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB3_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB3_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERROR
);

    localparam int              CNT_W      = wait_cnt_width(TIMEOUT_CYCLES);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    // Value the counter holds during the last permitted ACCESS cycle: it is 0
    // in the first ACCESS cycle, so TIMEOUT_CYCLES-1 marks cycle TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    apb3_state_e      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // The only combinational output: the command may be taken only in IDLE
    // and never while reset is asserted.
    assign cmd_ready   = (state == ST_IDLE) && resetn;
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    // NOTE: every flop here, the wait counter and the captured command
    // included, has an async reset value; sequential state uses <= only so
    // all branches see the pre-edge values of each other's registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR    <= cmd_addr;
                        PWRITE   <= cmd_write;
                        PWDATA   <= cmd_wdata;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // PREADY wins over a timeout reached in the same cycle.
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERROR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        // Saturates so a disabled timeout never wraps.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule : apb3_master

// File: tb/tb_apb3_master.sv
// -----------------------------------------------------------------------------
// tb_apb3_master
// Bench for apb3_master (TIMEOUT_CYCLES=8). The bench plays the APB slave
// (programmable wait states, error flag, small word memory) and the command /
// response agent. Expected results come from a transaction-level model.
// -----------------------------------------------------------------------------
module tb_apb3_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERROR;

    apb3_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] slave_mem [16];   // what the bench slave stores
    logic [DW-1:0] ref_mem   [16];   // what the model believes is stored

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transfer either completes after waits+1
    // ACCESS cycles or is cut off after TO of them.
    task automatic model(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic slverr,
                         output logic [DW-1:0] e_rdata, output logic e_err,
                         output logic e_to, output int e_lat);
        bit completes;
        completes = (waits < TO);
        e_lat     = 2 + (completes ? waits + 1 : TO);
        if (!completes) begin
            e_rdata = '0; e_err = 1'b1; e_to = 1'b1;
        end else begin
            e_rdata = wr ? '0 : ref_mem[addr[5:2]];
            e_err   = slverr;
            e_to    = 1'b0;
            if (wr) ref_mem[addr[5:2]] = wdata;
        end
    endtask

    // Drive one command, act as the slave, collect the response, hold
    // rsp_ready low for 'hold' cycles while pushing a competing command, then
    // complete the handshake. Per-cycle protocol checks are made on the way.
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic slverr, input int hold,
                          input logic fixed_en, input logic [DW-1:0] fixed_data,
                          output logic [DW-1:0] o_rdata, output logic o_err,
                          output logic o_to, output int o_lat, output int o_acc);
        bit done = 0;
        int acc = 0;
        o_lat = -1; o_rdata = '0; o_err = 1'b0; o_to = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            PREADY = 1'b0; PSLVERROR = 1'b0; PRDATA = $urandom;
            if (c == 1) begin
                cmd_valid = 1'b0;
                check("setup_psel", 64'(PSEL), 64'd1);
                check("setup_penable", 64'(PENABLE), 64'd0);
                check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            end
            check("penable_without_psel", 64'(PENABLE & ~PSEL), 64'd0);
            if (PSEL) begin
                check("paddr_stable", 64'(PADDR), 64'(addr));
                check("pwrite_stable", 64'(PWRITE), 64'(wr));
                check("pwdata_stable", 64'(PWDATA), 64'(wdata));
            end
            if (PSEL && PENABLE) begin
                if (acc == waits) begin
                    PREADY    = 1'b1;
                    PSLVERROR = slverr;
                    PRDATA    = fixed_en ? fixed_data : slave_mem[PADDR[5:2]];
                    if (PWRITE && !fixed_en) slave_mem[PADDR[5:2]] = PWDATA;
                end
                acc++;
            end
            if (rsp_valid) begin
                done    = 1;
                o_lat   = c;
                o_rdata = rsp_rdata;
                o_err   = rsp_err;
                o_to    = rsp_timeout;
                check("psel_low_in_resp", 64'(PSEL), 64'd0);
                check("penable_low_in_resp", 64'(PENABLE), 64'd0);
            end
        end
        o_acc = acc;
        PREADY = 1'b0;
        if (!done) begin
            check("rsp_valid_arrived", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = $urandom;
        rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'(o_rdata));
            check("hold_rsp_err", 64'(rsp_err), 64'(o_err));
            check("hold_rsp_timeout", 64'(rsp_timeout), 64'(o_to));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("hold_no_setup", 64'(PSEL), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_no_early_accept", 64'(PSEL), 64'd0);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;    // >= TO means PREADY never rises
        logic          slverr;
        int            hold;
        logic [DW-1:0] prdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
        int            exp_lat;  // cycles from accept to rsp_valid
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [DW-1:0] g_rdata, e_rdata;
        logic          g_err, g_to, e_err, e_to;
        int            g_lat, g_acc, e_lat;

        vecs[0] = '{1'b1, 12'h014, 32'hDEADBEEF, 1,   1'b0, 0, 32'h0,      32'h0,      1'b0, 1'b0, 4};
        vecs[1] = '{1'b0, 12'h040, 32'h0,      0,   1'b0, 0, 32'hABCD5678, 32'hABCD5678, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 12'h020, 32'h0,      100, 1'b0, 0, 32'h0,      32'h0,      1'b1, 1'b1, 10};
        vecs[3] = '{1'b0, 12'h024, 32'h0,      7,   1'b1, 0, 32'h00001234, 32'h00001234, 1'b1, 1'b0, 10};
        vecs[4] = '{1'b1, 12'h030, 32'hCAFEF00D, 6, 1'b0, 5, 32'h0,      32'h0,      1'b0, 1'b0, 9};
        vecs[5] = '{1'b0, 12'h03C, 32'h0,      2,   1'b1, 1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b0, 5};
        vecs[6] = '{1'b1, 12'hFFC, 32'h0,      8,   1'b0, 0, 32'h0,      32'h0,      1'b1, 1'b1, 10};

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end

        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERROR = 1'b0;
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout, PWRITE}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].slverr,
                   vecs[i].hold, 1'b1, vecs[i].prdata, g_rdata, g_err, g_to, g_lat, g_acc);
            check($sformatf("vec%0d_rdata", i), 64'(g_rdata), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i), 64'(g_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_timeout", i), 64'(g_to), 64'(vecs[i].exp_to));
            check($sformatf("vec%0d_latency", i), 64'(g_lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_access_cycles", i), 64'(g_acc), 64'(vecs[i].exp_lat - 2));
        end

        // Randomized traffic against the model, using the slave memory.
        for (int i = 0; i < 40; i++) begin
            logic          wr, se;
            logic [AW-1:0] ad;
            logic [DW-1:0] wd;
            int            ws, hd;
            wr = 1'($urandom_range(0, 1));
            ad = AW'({$urandom_range(0, 1023), 2'b00});
            wd = $urandom;
            ws = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
            se = ($urandom_range(0, 3) == 0);
            hd = $urandom_range(0, 3);
            model(wr, ad, wd, ws, se, e_rdata, e_err, e_to, e_lat);
            do_txn(wr, ad, wd, ws, se, hd, 1'b0, '0, g_rdata, g_err, g_to, g_lat, g_acc);
            check($sformatf("rnd%0d_rdata", i), 64'(g_rdata), 64'(e_rdata));
            check($sformatf("rnd%0d_err", i), 64'(g_err), 64'(e_err));
            check($sformatf("rnd%0d_timeout", i), 64'(g_to), 64'(e_to));
            check($sformatf("rnd%0d_latency", i), 64'(g_lat), 64'(e_lat));
        end

        // Reset asserted in the middle of ACCESS: abort with no response.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h080; cmd_wdata = 32'h11112222;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_access", 64'({PSEL, PENABLE}), 64'b11);
        #2 resetn = 1'b0;
        #1;
        check("abort_psel", 64'(PSEL), 64'd0);
        check("abort_penable", 64'(PENABLE), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        check("abort_paddr", 64'(PADDR), 64'd0);
        PREADY = 1'b1; PRDATA = 32'h99999999;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        end
        resetn = 1'b1; PREADY = 1'b0;
        @(negedge clk);
        check("abort_rsp_after_release", 64'(rsp_valid), 64'd0);
        check("abort_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("abort_psel_after", 64'(PSEL), 64'd0);

        // The block is usable again after the abort.
        do_txn(1'b0, 12'h044, 32'h0, 0, 1'b0, 0, 1'b1, 32'h0BADF00D, g_rdata, g_err, g_to, g_lat, g_acc);
        check("after_abort_rdata", 64'(g_rdata), 64'h0BADF00D);
        check("after_abort_latency", 64'(g_lat), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_apb3_master

// File: doc/apb3_master.md
APB3_MASTER -- requirements
Module: apb3_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles without PREADY; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
 - clk  input  1  single clock, rising edge.
 - resetn  input  1  asynchronous active-low reset.
 - cmd_valid  input  1  command request.
 - cmd_ready  output  1  command accepted when high together with cmd_valid.
 - cmd_write  input  1  1=write, 0=read.
 - cmd_addr  input  ADDR_WIDTH  byte address.
 - cmd_wdata  input  DATA_WIDTH  write data.
 - rsp_valid  output  1  response available.
 - rsp_ready  input  1  response consumed.
 - rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
 - rsp_err  output  1  PSLVERROR seen or timeout.
 - rsp_timeout  output  1  transfer ended by timeout.
 - PADDR  output  ADDR_WIDTH  APB address.
 - PSEL  output  1  APB select.
 - PENABLE  output  1  APB enable.
 - PWRITE  output  1  APB direction.
 - PWDATA  output  DATA_WIDTH  APB write data.
 - PRDATA  input  DATA_WIDTH  APB read data.
 - PREADY  input  1  APB ready.
 - PSLVERROR  input  1  APB slave error.

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; all outputs except cmd_ready SHALL be registered.
REQ-006 cmd_ready SHALL equal (state==IDLE) AND resetn.
REQ-007 IDLE: on cmd_valid & cmd_ready, SHALL latch write/addr/wdata onto PWRITE/PADDR/PWDATA and go to SETUP; otherwise SHALL stay in IDLE.
REQ-008 SETUP: SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS unconditionally.
REQ-009 ACCESS: SHALL drive PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA SHALL stay stable from SETUP until the end of ACCESS.
REQ-010 ACCESS with PREADY=1: SHALL capture rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERROR and rsp_timeout=0, then go to RESP.
REQ-011 ACCESS with PREADY=0: SHALL increment the wait counter (width $clog2(TIMEOUT_CYCLES+1)); when the counter equals TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES>0, SHALL go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-012 PREADY=1 in the same cycle the timeout threshold is reached SHALL take priority, completing normally (REQ-010).
REQ-013 The wait counter SHALL clear on entry to SETUP and SHALL never wrap.
REQ-014 On any exit from ACCESS: PSEL and PENABLE SHALL drop to 0 in the next cycle.
REQ-015 RESP: SHALL hold rsp_valid=1 and the response fields stable until rsp_ready=1, then go to IDLE with rsp_valid=0.
REQ-016 Latency: command accepted in cycle N gives PSEL=1 in N+1, PENABLE=1 in N+2, and rsp_valid=1 in N+3 when PREADY=1 in N+2.
REQ-017 Throughput: minimum 4 cycles per transfer; the next command SHALL NOT be accepted before the cycle after the rsp handshake.
REQ-018 PSEL SHALL never be high in IDLE or RESP; PENABLE SHALL never be high without PSEL.

Reset
REQ-019 resetn low SHALL asynchronously force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and wait counter=0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer with no response; after release, the block SHALL be in IDLE with cmd_ready=1.

Structure
REQ-021 Package apb3_pkg SHALL hold the FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11) and the APB3 default widths.
REQ-022 The block SHALL have no sub-module; the wait counter SHALL be inline.

Verification
REQ-023 Write 0x14 <- 0xDEADBEEF to a slave with one wait state -> PSEL/PENABLE timing per REQ-016+1, PWDATA stable, rsp_err=0, rsp_rdata=0.
REQ-024 Read 0x40 from a zero-wait slave returning 0xABCD5678 -> rsp_valid in cycle N+3, rsp_rdata=0xABCD5678, rsp_err=0.
REQ-025 TIMEOUT_CYCLES=8 with PREADY held at 0 -> exactly 8 ACCESS cycles, then rsp_err=1, rsp_timeout=1, PSEL=0 on the next cycle.
REQ-026 PREADY=1 on the 8th ACCESS cycle (TIMEOUT_CYCLES=8) together with PSLVERROR=1 -> rsp_err=1, rsp_timeout=0.
REQ-027 rsp_ready held at 0 for 5 cycles while cmd_valid=1 -> rsp stable, cmd_ready=0, no new SETUP; resetn pulsed low in ACCESS -> PSEL=0 at once, rsp_valid stays 0.
